// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code serial receive path.
package gray_pkg;

  // Receive FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } gray_state_t;

  // Default word width for Gray encoders/decoders
  localparam int GRAY_W_DEF = 3;

endpackage

// File: rtl/gray_step_checker.sv
// Remembers the previous completed word and flags any new word that is not
// exactly one step (+1 or -1, wrapping in WIDTH bits) away from it.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             load,
  output logic             step_err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] history;
  logic             hist_valid;
  logic [WIDTH-1:0] prev_plus;
  logic [WIDTH-1:0] prev_minus;
  logic             is_step;

  // Neighbours of the previous word, wrapping naturally in WIDTH bits
  always_comb begin
    prev_plus  = history + ONE;
    prev_minus = history - ONE;
    is_step    = (word == prev_plus) || (word == prev_minus);
  end

  // History update and registered error pulse; the first word after reset has no reference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history    <= '0;
      hist_valid <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      step_err <= load && hist_valid && !is_step;
      if (load) begin
        history    <= word;
        hist_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_serial_decoder.sv
// Serial MSB-first Gray-to-binary decoder: each accepted bit is folded into a
// running parity so the binary word is ready the moment the last bit arrives.
module gray_serial_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gin,
  input  logic             gin_valid,
  output logic [WIDTH-1:0] bout,
  output logic             bout_valid,
  output logic             busy,
  output logic             step_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  gray_state_t      state;
  logic [IW-1:0]    index;
  logic             r;
  logic [WIDTH-1:0] shadow;

  logic             r_next;
  logic [WIDTH-1:0] word_next;
  logic             frame_done;

  // Next parity bit, shadow word with the current bit folded in, and frame completion
  always_comb begin
    r_next           = r ^ gin;
    word_next        = shadow;
    word_next[index] = r_next;
    frame_done       = (state == SHIFT) && gin_valid && (index == '0);
  end

  // Receive FSM with index counter, running parity and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      index      <= IDX_TOP;
      r          <= 1'b0;
      shadow     <= '0;
      bout       <= '0;
      bout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bout_valid <= 1'b0;
      case (state)
        IDLE: begin
          index <= IDX_TOP;
          r     <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (gin_valid) begin
            r      <= r_next;
            shadow <= word_next;
            if (index == '0) begin
              bout       <= word_next;
              bout_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              index <= index - IDX_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  gray_step_checker #(
    .WIDTH (WIDTH)
  ) u_step_checker (
    .clk      (clk),
    .rst      (rst),
    .word     (word_next),
    .load     (frame_done),
    .step_err (step_err)
  );

endmodule

// File: tb/tb_gray_serial_decoder.sv
// Self-checking bench for gray_serial_decoder (WIDTH=3): directed frames from
// the test plan followed by randomized frames with stalls and stray starts.
module tb_gray_serial_decoder;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         gin;
  logic         gin_valid;
  logic [W-1:0] bout;
  logic         bout_valid;
  logic         busy;
  logic         step_err;

  int checkCount = 0;
  int passCount  = 0;

  // Reference history: previous decoded word and whether one exists
  bit hasPrev  = 1'b0;
  int prevWord = 0;

  gray_serial_decoder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gin        (gin),
    .gin_valid  (gin_valid),
    .bout       (bout),
    .bout_valid (bout_valid),
    .busy       (busy),
    .step_err   (step_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Gray to binary: binary is the XOR of all right shifts of the Gray word
  function automatic int grayToBin(input int g);
    int b;
    b = 0;
    for (int k = 0; k < W; k++) b ^= (g >> k);
    return b & ((1 << W) - 1);
  endfunction

  // A word is a legal step when it differs from the previous by +1 or -1 modulo 2^W
  function automatic bit isStepError(input int newWord);
    int d;
    if (!hasPrev) return 1'b0;
    d = (newWord - prevWord + (1 << W)) % (1 << W);
    return !((d == 1) || (d == (1 << W) - 1));
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  // Drive one frame starting at a negedge; checks timing, busy, the result and the pulse width
  task automatic applyStimulus(input logic [W-1:0] g, input int stallMax, input int forcedStall,
                               input bit pokeStart, input bit startAlready, input bit b2bNext);
    int  expWord;
    bit  expErr;
    int  cycles;
    int  totalStalls;
    int  stalls;
    expWord     = grayToBin(int'(g));
    expErr      = isStepError(expWord);
    totalStalls = 0;
    if (!startAlready) start = 1'b1;
    gin_valid = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    checkOutput("busy_rise", int'(busy), 1);
    checkOutput("valid_low_start", int'(bout_valid), 0);
    for (int i = W - 1; i >= 0; i--) begin
      stalls = (stallMax > 0) ? int'($urandom_range(stallMax, 0)) : 0;
      if (i == W - 2) stalls += forcedStall;
      totalStalls += stalls;
      repeat (stalls) begin
        gin_valid = 1'b0;
        gin       = 1'($urandom_range(1, 0));
        start     = pokeStart ? 1'($urandom_range(1, 0)) : 1'b0;
        @(negedge clk);
        cycles++;
        checkOutput("busy_stall", int'(busy), 1);
        checkOutput("valid_low_stall", int'(bout_valid), 0);
      end
      gin_valid = 1'b1;
      gin       = g[i];
      start     = pokeStart ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
      cycles++;
      if (i > 0) begin
        checkOutput("busy_bit", int'(busy), 1);
        checkOutput("valid_low_bit", int'(bout_valid), 0);
      end
    end
    gin_valid = 1'b0;
    start     = b2bNext;
    checkOutput("bout_valid", int'(bout_valid), 1);
    checkOutput("bout", int'(bout), expWord);
    checkOutput("step_err", int'(step_err), int'(expErr));
    checkOutput("busy_fall", int'(busy), 0);
    checkOutput("latency", cycles, W + 1 + totalStalls);
    hasPrev  = 1'b1;
    prevWord = expWord;
    if (!b2bNext) begin
      @(negedge clk);
      checkOutput("valid_pulse_end", int'(bout_valid), 0);
      checkOutput("err_pulse_end", int'(step_err), 0);
      checkOutput("bout_hold", int'(bout), expWord);
    end
  endtask

  // Main sequence: directed test plan, then randomized frames
  initial begin
    bit chained;
    bit nextB2b;
    rst       = 1'b1;
    start     = 1'b0;
    gin       = 1'b0;
    gin_valid = 1'b0;
    #1;
    checkOutput("rst_bout", int'(bout), 0);
    checkOutput("rst_valid", int'(bout_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_err", int'(step_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Decode, legal step, illegal jump
    applyStimulus(3'b110, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b111, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 0, 0, 1'b0, 1'b0, 1'b0);
    // Wrap-around and repeated word
    applyStimulus(3'b100, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 0, 0, 1'b0, 1'b0, 1'b0);
    // Stall of 3 cycles after the first bit, with stray start pulses
    applyStimulus(3'b011, 0, 3, 1'b1, 1'b0, 1'b0);

    // Reset after two of three bits
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    gin_valid = 1'b1;
    gin       = 1'b1;
    @(negedge clk);
    gin = 1'b0;
    @(negedge clk);
    gin_valid = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("midrst_bout", int'(bout), 0);
    checkOutput("midrst_valid", int'(bout_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_err", int'(step_err), 0);
    hasPrev  = 1'b0;
    prevWord = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_valid", int'(bout_valid), 0);
    applyStimulus(3'b010, 0, 0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames 0,1,2,3
    applyStimulus(3'b000, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b001, 0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(3'b011, 0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(3'b010, 0, 0, 1'b0, 1'b1, 1'b0);

    // Randomized frames with random stalls, stray starts and chaining
    chained = 1'b0;
    for (int n = 0; n < 40; n++) begin
      nextB2b = (n < 39) ? 1'($urandom_range(1, 0)) : 1'b0;
      applyStimulus(W'($urandom_range((1 << W) - 1, 0)), int'($urandom_range(2, 0)), 0,
                    1'($urandom_range(1, 0)), chained, nextB2b);
      chained = nextB2b;
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
